pwr_cntr_ctrl: RTL and testbench



---
 rtl/pwr_cntr_pkg.sv | 11 +
 rtl/pwr_cntr_ctrl_if.sv | 15 +
 rtl/pwr_cntr_ctrl_rr_arbiter.sv | 25 ++
 rtl/pwr_cntr_ctrl.sv | 106 ++++++++++
 tb/tb_pwr_cntr_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwr_cntr_pkg.sv
// Shared types and helpers for the transition-counter sequencer.
package pwr_cntr_pkg;
  localparam int CW = 32;
  localparam logic [CW-1:0] SAT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, LEER, ESCRIBIR, LIMPIAR} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == SAT_MAX) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/pwr_cntr_ctrl_if.sv
// Probe-side and memory-address/control signals of the counter sequencer.
interface pwr_cntr_ctrl_if #(
  parameter int NumPwrCntr = 2,
  parameter int Ndir       = 1
);
  logic [NumPwrCntr:0] senal;
  logic                limpiar;
  logic [Ndir:0]       mem_dir;
  logic                mem_LE;
  logic                ocupado;
  logic [NumPwrCntr:0] perdida;

  modport master (input senal, limpiar, output mem_dir, mem_LE, ocupado, perdida);
  modport slave  (output senal, limpiar, input mem_dir, mem_LE, ocupado, perdida);
endinterface

// File: rtl/pwr_cntr_ctrl_rr_arbiter.sv
// Round-robin pick among pending channels, searching from rr+1 upward with wrap.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr,
  output logic [IW-1:0] gnt,
  output logic          vld
);
  int best;

  // Distance from rr+1 in wrap order; the smallest distance wins.
  always_comb begin
    gnt  = '0;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (req[i] && ((i - int'(rr) - 1 + 2 * N) % N) < best) begin
        best = (i - int'(rr) - 1 + 2 * N) % N;
        gnt  = IW'(i);
      end
    end
    vld = |req;
  end
endmodule

// File: rtl/pwr_cntr_ctrl.sv
// Toggle counter sequencer: detects probe toggles and read-increment-writes
// saturating 32-bit counters in an external memory; also bulk-clears them.
module pwr_cntr_ctrl
  import pwr_cntr_pkg::*;
#(
  parameter int NumPwrCntr = 2,
  parameter int Ndir       = 1
) (
  input  logic            clk,
  input  logic            reset,
  pwr_cntr_ctrl_if.master bus,
  inout  wire  [CW-1:0]   mem_dato
);
  localparam int N = NumPwrCntr + 1;
  localparam logic [Ndir:0] LAST = (Ndir + 1)'(NumPwrCntr);

  state_t        state, state_n;
  logic [N-1:0]  senal_prev, tog, pend, pend_n, perd, perd_n, gmask;
  logic [Ndir:0] dir_q, dir_n, rr, gnt;
  logic          le_q, le_n, ocu_q, lp, lp_n, gnt_vld, take, flush;
  logic [CW-1:0] dato_q, dato_n;

  assign tog = bus.senal ^ senal_prev;

  rr_arbiter #(.N(N), .IW(Ndir + 1)) u_arb (
    .req(pend), .rr(rr), .gnt(gnt), .vld(gnt_vld)
  );

  always_comb begin
    state_n = state;
    dir_n   = dir_q;
    le_n    = 1'b1;
    dato_n  = dato_q;
    take    = 1'b0;
    case (state)
      // IDLE and ESCRIBIR share the same next-step priority.
      IDLE, ESCRIBIR: begin
        if (bus.limpiar || lp) begin
          state_n = LIMPIAR;
          dir_n   = '0;
          le_n    = 1'b0;
          dato_n  = '0;
        end else if (gnt_vld) begin
          state_n = LEER;
          dir_n   = gnt;
          take    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      LEER: begin
        state_n = ESCRIBIR;
        le_n    = 1'b0;
        dato_n  = sat_inc(mem_dato);
      end
      LIMPIAR: begin
        if (dir_q == LAST) begin
          state_n = IDLE;
        end else begin
          le_n   = 1'b0;
          dato_n = '0;
          dir_n  = dir_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A toggle on the channel granted this cycle re-arms pend instead of being lost.
    flush  = (state_n == LIMPIAR) || (state == LIMPIAR);
    gmask  = take ? (N'(1) << gnt) : '0;
    pend_n = flush ? '0 : ((pend & ~gmask) | tog);
    perd_n = flush ? '0 : (perd | (tog & pend & ~gmask));
    lp_n   = flush ? 1'b0 : (lp | bus.limpiar);
  end

  always_ff @(posedge clk) begin
    senal_prev <= bus.senal;
    if (reset) begin
      state  <= IDLE;
      dir_q  <= '0;
      le_q   <= 1'b1;
      dato_q <= '0;
      ocu_q  <= 1'b0;
      pend   <= '0;
      perd   <= '0;
      rr     <= '0;
      lp     <= 1'b0;
    end else begin
      state  <= state_n;
      dir_q  <= dir_n;
      le_q   <= le_n;
      dato_q <= dato_n;
      ocu_q  <= (state_n != IDLE);
      pend   <= pend_n;
      perd   <= perd_n;
      lp     <= lp_n;
      if (take) rr <= gnt;
    end
  end

  assign bus.mem_dir = dir_q;
  assign bus.mem_LE  = le_q;
  assign bus.ocupado = ocu_q;
  assign bus.perdida = perd;
  assign mem_dato    = le_q ? {CW{1'bz}} : dato_q;
endmodule

// File: tb/tb_pwr_cntr_ctrl.sv
// Directed + randomized bench for pwr_cntr_ctrl with a behavioural counter memory.
module tb_pwr_cntr_ctrl;
  localparam int NP = 2;
  localparam int ND = 1;
  localparam int N  = NP + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pwr_cntr_ctrl_if #(.NumPwrCntr(NP), .Ndir(ND)) bus();
  wire [31:0] mem_dato;

  pwr_cntr_ctrl #(.NumPwrCntr(NP), .Ndir(ND)) dut (
    .clk(clk), .reset(reset), .bus(bus), .mem_dato(mem_dato)
  );

  logic [31:0] mem      [0:3];
  logic [31:0] load_val [0:3];
  logic        load = 1'b0;
  int          waddr[$];
  logic [31:0] wdata[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_m [0:2];
  int          rr_m;
  int          base;

  // Memory model: drives the bus on reads, logs every write cycle.
  assign mem_dato = bus.mem_LE ? mem[bus.mem_dir] : 32'bz;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4; i++) mem[i] <= load_val[i];
    end else if (!bus.mem_LE) begin
      mem[bus.mem_dir] <= mem_dato;
      waddr.push_back(int'(bus.mem_dir));
      wdata.push_back(mem_dato);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] inc_sat(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) return v;
    return v + 32'd1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'hFFFF_FFFE;
      default: return $urandom;
    endcase
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    load_val[0] = a; load_val[1] = b; load_val[2] = c; load_val[3] = 32'd0;
    exp_m[0] = a; exp_m[1] = b; exp_m[2] = c;
    load = 1'b1;
    step;
    load = 1'b0;
  endtask

  // Toggle a set of channels once and check service order, values and busy time.
  task automatic burst(input logic [2:0] m);
    int b0, oc, idx;
    int ord[$];
    b0 = waddr.size();
    for (int j = 1; j <= N; j++) begin
      idx = (rr_m + j) % N;
      if (((m >> idx) & 3'd1) != 3'd0) ord.push_back(idx);
    end
    if (ord.size() > 0) rr_m = ord[ord.size() - 1];
    bus.senal = bus.senal ^ m;
    oc = 0;
    repeat (2 * N + 4) begin
      step;
      if (bus.ocupado) oc++;
    end
    chk("busy_cycles", 64'(oc), 64'(2 * ord.size()));
    chk("n_writes", 64'(waddr.size() - b0), 64'(ord.size()));
    for (int j = 0; j < ord.size(); j++) begin
      exp_m[ord[j]] = inc_sat(exp_m[ord[j]]);
      if (b0 + j < waddr.size()) begin
        chk("wr_dir", 64'(waddr[b0 + j]), 64'(ord[j]));
        chk("wr_dato", 64'(wdata[b0 + j]), 64'(exp_m[ord[j]]));
      end
    end
    for (int i = 0; i < N; i++) chk("mem", 64'(mem[i]), 64'(exp_m[i]));
    chk("perdida_clean", 64'(bus.perdida), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.senal   = '0;
    bus.limpiar = 1'b0;
    reset       = 1'b1;
    preload(32'd5, 32'd5, 32'd5);
    step;
    chk("rst_le", 64'(bus.mem_LE), 64'd1);
    chk("rst_ocupado", 64'(bus.ocupado), 64'd0);
    chk("rst_perdida", 64'(bus.perdida), 64'd0);
    chk("rst_dir", 64'(bus.mem_dir), 64'd0);
    chk("rst_dato_released", 64'(mem_dato), 64'(mem[0]));
    reset = 1'b0;
    rr_m  = 0;
    step;

    // Single toggle on channel 1.
    bus.senal = bus.senal ^ 3'b010;
    step;
    chk("t1_idle_ocupado", 64'(bus.ocupado), 64'd0);
    step;
    chk("t1_leer_le", 64'(bus.mem_LE), 64'd1);
    chk("t1_leer_dir", 64'(bus.mem_dir), 64'd1);
    chk("t1_leer_ocupado", 64'(bus.ocupado), 64'd1);
    step;
    chk("t1_wr_le", 64'(bus.mem_LE), 64'd0);
    chk("t1_wr_dir", 64'(bus.mem_dir), 64'd1);
    chk("t1_wr_dato", 64'(mem_dato), 64'd6);
    chk("t1_wr_ocupado", 64'(bus.ocupado), 64'd1);
    step;
    chk("t1_done_ocupado", 64'(bus.ocupado), 64'd0);
    chk("t1_done_le", 64'(bus.mem_LE), 64'd1);
    chk("t1_mem0", 64'(mem[0]), 64'd5);
    chk("t1_mem1", 64'(mem[1]), 64'd6);
    chk("t1_mem2", 64'(mem[2]), 64'd5);
    rr_m = 1;

    // Simultaneous toggles, then saturation.
    preload(32'd0, 32'd0, 32'd0);
    burst(3'b111);
    preload(32'd5, 32'd5, 32'hFFFF_FFFF);
    burst(3'b100);

    // Channel 0 toggles twice while channel 1 is being serviced.
    preload(32'd0, 32'd0, 32'd0);
    bus.senal = bus.senal ^ 3'b010;
    step;
    bus.senal = bus.senal ^ 3'b001;
    step;
    bus.senal = bus.senal ^ 3'b001;
    step;
    chk("t4_perdida", 64'(bus.perdida), 64'd1);
    repeat (8) step;
    chk("t4_mem0", 64'(mem[0]), 64'd1);
    chk("t4_mem1", 64'(mem[1]), 64'd1);
    chk("t4_mem2", 64'(mem[2]), 64'd0);
    chk("t4_perdida_sticky", 64'(bus.perdida), 64'd1);
    rr_m = 0;

    // limpiar during LEER of channel 1.
    preload(32'd7, 32'd7, 32'd7);
    bus.senal = bus.senal ^ 3'b010;
    step;
    step;
    chk("t5_leer_dir", 64'(bus.mem_dir), 64'd1);
    bus.limpiar = 1'b1;
    step;
    bus.limpiar = 1'b0;
    chk("t5_wr_le", 64'(bus.mem_LE), 64'd0);
    chk("t5_wr_dato", 64'(mem_dato), 64'd8);
    step;
    chk("t5_clr0_le", 64'(bus.mem_LE), 64'd0);
    chk("t5_clr0_dir", 64'(bus.mem_dir), 64'd0);
    chk("t5_clr0_dato", 64'(mem_dato), 64'd0);
    chk("t5_clr_perdida", 64'(bus.perdida), 64'd0);
    step;
    chk("t5_clr1_dir", 64'(bus.mem_dir), 64'd1);
    step;
    chk("t5_clr2_dir", 64'(bus.mem_dir), 64'd2);
    chk("t5_clr2_ocupado", 64'(bus.ocupado), 64'd1);
    step;
    chk("t5_end_ocupado", 64'(bus.ocupado), 64'd0);
    chk("t5_end_le", 64'(bus.mem_LE), 64'd1);
    for (int i = 0; i < N; i++) chk("t5_mem_zero", 64'(mem[i]), 64'd0);
    exp_m[0] = 0; exp_m[1] = 0; exp_m[2] = 0;
    rr_m = 1;

    // Reset while writing channel 2, with a probe edge during reset.
    bus.senal = bus.senal ^ 3'b100;
    step;
    step;
    step;
    chk("t6_wr_le", 64'(bus.mem_LE), 64'd0);
    reset     = 1'b1;
    bus.senal = bus.senal ^ 3'b001;
    step;
    chk("t6_rst_le", 64'(bus.mem_LE), 64'd1);
    chk("t6_rst_ocupado", 64'(bus.ocupado), 64'd0);
    chk("t6_rst_dato_released", 64'(mem_dato), 64'(mem[bus.mem_dir]));
    reset = 1'b0;
    base  = waddr.size();
    repeat (8) step;
    chk("t6_no_writes", 64'(waddr.size() - base), 64'd0);
    chk("t6_idle_ocupado", 64'(bus.ocupado), 64'd0);
    chk("t6_mem0", 64'(mem[0]), 64'd0);
    rr_m = 0;

    // Randomized bursts against the reference model.
    repeat (24) begin
      preload(pick(), pick(), pick());
      burst(3'($urandom_range(1, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
